mac_norm_round_pipe: RTL and testbench
======================================

Name: mac_norm_round_pipe

Overview:
- Parametrised successor to the MAC-subsystem exponent-handling/normalisation stage.
- Takes the unnormalised accumulator magnitude, sign and pre-biased exponent, then finds the leading one, normalises and computes the final exponent.
- Handles subnormal shift, overflow saturation and zero, optionally rounds, and packs a sign/exponent/mantissa float.
- Two-stage valid/ready pipeline between MAC accumulator and output buffer; sticky status flags for firmware.

Parameters:
- EXP_W, 5, output exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 10, output mantissa field width; FP_W = 1+EXP_W+MAN_W.
- SUM_W, 16, accumulator magnitude width (must be >= MAN_W+1).
- EIN_W, 8, signed input exponent width (two's complement).
- Q_W, 5, fractional-shift config width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, stage 1 can accept.
- in_sum, input, SUM_W, unsigned magnitude; leading one may be at any bit.
- in_sign, input, 1, result sign.
- in_exp, input, EIN_W, signed biased exponent the result has if the leading one is at bit SUM_W-1.
- q_frac, input, Q_W, unsigned static fractional shift; subtracted from exponent.
- out_valid, output, 1, packed result valid.
- out_ready, input, 1, downstream accepts.
- out_fp, output, FP_W, {sign, exp, man}.
- clr_flags, input, 1, clears sticky flags.
- flag_ovf, output, 1, sticky: saturation occurred.
- flag_unf, output, 1, sticky: nonzero input flushed to zero.
- flag_inx, output, 1, sticky: nonzero bits discarded.

Behaviour:
- Reset (rst_n=0 at clk edge): s1/s2 valid=0, out_fp=0, flags=0; in_ready=1 the cycle after reset.
- Pipeline rules:
  - Latency 2 cycles, throughput 1/cycle.
  - s2 advances when !s2_valid | out_ready; s1 advances when !s1_valid | s2 advances.
  - in_ready = !s1_valid | s1 advances (combinational, no bubble).
  - out_fp/out_valid are registered and held stable while out_valid & !out_ready.
- Stage 1 (on in_valid & in_ready):
  - Register lzc = count of leading zeros of in_sum (SUM_W if zero), the normalised sum (in_sum << lzc), sign, zero flag, and e = in_exp - lzc - q_frac.
  - Arithmetic is sign-extended to EIN_W+2 bits, with no wrap.
- Stage 2 (registered into out_fp):
  - zero: out = {sign, 0}; no flags.
  - e >= 1: mantissa = normalised bits [SUM_W-2 -: MAN_W]; guard = next bit; sticky = OR of the rest.
  - e <= 0: shift the normalised value right by (1-e), hidden bit included; exp field = 0. If 1-e > MAN_W+1, the result is {sign, 0} and flag_unf is set.
  - Rounding is per the Optional Feature. A rounding carry increments the exponent; a subnormal may carry into exp=1.
  - After rounding, e >= 2^EXP_W-1: saturate to {sign, 2^EXP_W-2, all ones}; set flag_ovf. Inf is never produced.
  - Any discarded nonzero bit sets flag_inx; so does saturation or flush.
- Flags:
  - Flags update only on out_valid & out_ready.
  - When clr_flags and a set occur in the same cycle, set wins.
- Reset mid-operation: in-flight beats are dropped with no output.

Optional Feature:
- Macro MAC_NORM_RNE_EN.
- Defined: round-to-nearest-even using guard/sticky and mantissa LSB, in both normal and subnormal paths.
- Undefined: truncation (round toward zero); carry logic and its exponent increment are absent; flag_inx still reported.

Test Plan:
- Defaults; in_sum=16'h8000, in_exp=15, q_frac=0, sign=0, out_ready=1 -> out_fp=16'h3C00 two cycles after acceptance; no flags.
- in_sum=16'h0001, in_exp=15, q_frac=0 -> e=0, out_fp=16'h0200. Same input with q_frac=10 -> 16'h0000, flag_unf=1, flag_inx=1.
- in_sum=16'h8000, in_exp=31, sign=1 -> out_fp=16'hFBFF, flag_ovf=1. Then clr_flags=1 for one cycle -> all flags 0.
- in_sum=16'hFFF0, in_exp=15 -> 16'h4000 with MAC_NORM_RNE_EN; 16'h3FFF without. flag_inx=1 in both cases.
- Stream 4 back-to-back beats with out_ready=0 for cycles 3-6 -> in_ready=0 once both stages are full; out_fp stable while stalled; all 4 results delivered in order, none lost or duplicated.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 and out_fp=0 next cycle; no stale beat appears after reset release.

Source files
------------

// File: rtl/mac_norm_round_pipe.sv
// mac_norm_round_pipe
//   Two-stage normalise/round/pack stage between the MAC accumulator and the
//   output buffer. Stage 1 finds the leading one of the accumulator magnitude,
//   normalises it and computes the unbounded exponent. Stage 2 handles zero,
//   subnormal shift, flush-to-zero, optional rounding and overflow saturation,
//   then registers the packed {sign, exp, man} result.
//
// Build option:
//   MAC_NORM_RNE_EN  defined   -> round-to-nearest-even (normal and subnormal)
//                    undefined -> truncation toward zero (no carry path)
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_sum, in_sign      unsigned accumulator magnitude and result sign
//   in_exp               signed biased exponent for a leading one at SUM_W-1
//   q_frac               static fractional shift subtracted from the exponent
//   out_valid/out_ready  packed result handshake
//   out_fp               {sign, exp[EXP_W], man[MAN_W]}
//   clr_flags            clears the sticky flags (a same-cycle set wins)
//   flag_ovf/unf/inx     sticky saturation / flush-to-zero / inexact flags
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid & ready are both high. The producer holds valid and data stable until
// that edge; ready may depend combinationally on downstream ready.
module mac_norm_round_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int SUM_W = 16,
  parameter int EIN_W = 8,
  parameter int Q_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SUM_W-1:0]       in_sum,
  input  logic                   in_sign,
  input  logic [EIN_W-1:0]       in_exp,
  input  logic [Q_W-1:0]         q_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_fp,
  input  logic                   clr_flags,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inx
);

  localparam int EW   = EIN_W + 2;
  localparam int LZ_W = $clog2(SUM_W + 1);
  // Normalised value padded with MAN_W+2 zero LSBs: a subnormal shift of up
  // to MAN_W+1 only moves zeros out, so guard/sticky never miss a bit.
  localparam int WW   = SUM_W + MAN_W + 2;

  localparam logic signed [EW-1:0] E_ZERO  = '0;
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);
  localparam logic signed [EW-1:0] E_SAT   = EW'((1 << EXP_W) - 1);
  localparam logic        [EW-1:0] SH_MAX  = EW'(MAN_W + 1);
  localparam logic     [EXP_W-1:0] EXP_MAX = EXP_W'((1 << EXP_W) - 2);

  // ---------------- pipeline control ----------------
  logic s1_valid;
  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1: leading-zero count ----------------
  logic [LZ_W-1:0]        lzc;
  logic signed [EW-1:0]   e_calc;

  always_comb begin
    lzc = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (in_sum[i]) lzc = LZ_W'(SUM_W - 1 - i);
    end
  end

  assign e_calc = EW'($signed(in_exp)) - EW'(lzc) - EW'(q_frac);

  logic [SUM_W-1:0]     s1_norm;
  logic                 s1_sign, s1_zero;
  logic signed [EW-1:0] s1_e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_norm  <= '0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_e     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_norm <= in_sum << lzc;
        s1_sign <= in_sign;
        s1_zero <= (in_sum == '0);
        s1_e    <= e_calc;
      end
    end
  end

  // ---------------- stage 2: shift, round, saturate, pack ----------------
  logic [WW-1:0]        wide;
  logic [EW-1:0]        sh_amt;
  logic                 normal, flush, guard, sticky, sat;
  logic [MAN_W-1:0]     man;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_base, exp_r;
  logic [EXP_W+MAN_W:0] fp_d;
  logic                 ovf_d, unf_d, inx_d;

  always_comb begin
    wide   = {s1_norm, {(MAN_W + 2){1'b0}}};
    normal = (s1_e > E_ZERO);
    sh_amt = E_ONE - s1_e;
    flush  = 1'b0;
    if (!normal) begin
      if (sh_amt > SH_MAX) flush = 1'b1;
      else                 wide  = wide >> sh_amt;
    end
    man      = wide[WW-2 -: MAN_W];
    guard    = wide[WW-2-MAN_W];
    sticky   = |wide[WW-3-MAN_W:0];
    exp_base = normal ? s1_e : E_ZERO;
`ifdef MAC_NORM_RNE_EN
    // Round up on guard when above half-way, or at a tie with odd LSB. A
    // mantissa carry bumps the exponent (subnormal 0x3FF+1 becomes exp=1).
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, guard & (sticky | man[0])};
    exp_r = exp_base + {{(EW-1){1'b0}}, man_r[MAN_W]};
`else
    man_r = {1'b0, man};
    exp_r = exp_base;
`endif
    sat = normal && (exp_r >= E_SAT);

    fp_d  = {s1_sign, {(EXP_W + MAN_W){1'b0}}};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (s1_zero) begin
      fp_d = {s1_sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (flush) begin
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (sat) begin
      fp_d  = {s1_sign, EXP_MAX, {MAN_W{1'b1}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      fp_d  = {s1_sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      inx_d = guard | sticky;
      // A nonzero input that rounds/truncates to zero is an underflow too.
      unf_d = (exp_r == E_ZERO) && (man_r[MAN_W-1:0] == '0);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wide[WW-1], exp_r[EW-1:EXP_W], man_r[MAN_W]};

  logic beat_ovf, beat_unf, beat_inx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_fp    <= '0;
      beat_ovf  <= 1'b0;
      beat_unf  <= 1'b0;
      beat_inx  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_fp   <= fp_d;
        beat_ovf <= ovf_d;
        beat_unf <= unf_d;
        beat_inx <= inx_d;
      end
    end
  end

  // ---------------- sticky flags ----------------
  // Status of a beat is committed only when the beat is taken downstream;
  // clearing first and OR-ing afterwards lets a same-cycle set win.
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
    end else begin
      flag_ovf <= (flag_ovf && !clr_flags) || (out_fire && beat_ovf);
      flag_unf <= (flag_unf && !clr_flags) || (out_fire && beat_unf);
      flag_inx <= (flag_inx && !clr_flags) || (out_fire && beat_inx);
    end
  end

endmodule

// File: tb/tb_mac_norm_round_pipe.sv
// tb_mac_norm_round_pipe
//   Directed vectors with hand-computed results. The driver pushes each
//   expected packed value into exp_q at issue time; an independent monitor
//   pops and compares whenever a result is handed downstream, and also checks
//   that a stalled output holds. Sticky flags and reset behaviour are checked
//   from the main sequence.
module tb_mac_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sum = '0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [4:0]  q_frac = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_fp;
  logic        clr_flags = 1'b0;
  logic        flag_ovf, flag_unf, flag_inx;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  mac_norm_round_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .q_frac    (q_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .clr_flags (clr_flags),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_flags(input string name, input logic o, input logic u, input logic i);
    check({name, "_ovf"}, {31'b0, flag_ovf}, {31'b0, o});
    check({name, "_unf"}, {31'b0, flag_unf}, {31'b0, u});
    check({name, "_inx"}, {31'b0, flag_inx}, {31'b0, i});
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] sum, input logic [7:0] ex, input logic [4:0] qf,
                      input logic sg, input logic [15:0] exp_fp, input bit keep);
    int n;
    @(negedge clk);
    in_sum   = sum;
    in_exp   = ex;
    q_frac   = qf;
    in_sign  = sg;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready got 0 expected 1 at %0t", $time);
    end else if (keep) begin
      exp_q.push_back(exp_fp);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #3;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic        stalled;
    logic [15:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_fp", {16'b0, out_fp}, {16'b0, held});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got %h expected none at %0t", out_fp, $time);
          end else begin
            check("out_fp", {16'b0, out_fp}, {16'b0, exp_q.pop_front()});
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_fp;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_fp", {16'b0, out_fp}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1.0 with latency: empty after the accepting edge, valid after the next
    send(16'h8000, 8'd15, 5'd0, 1'b0, 16'h3C00, 1);
    check("lat_s1", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_out", {31'b0, out_valid}, 32'd1);
    drain();
    check_flags("one", 1'b0, 1'b0, 1'b0);

    // Smallest input at e=0 (exact subnormal), then flushed with q_frac=10
    send(16'h0001, 8'd15, 5'd0, 1'b0, 16'h0200, 1);
    drain();
    check_flags("subn", 1'b0, 1'b0, 1'b0);
    send(16'h0001, 8'd15, 5'd10, 1'b0, 16'h0000, 1);
    drain();
    check_flags("flush", 1'b0, 1'b1, 1'b1);
    pulse_clr();
    check_flags("clr1", 1'b0, 1'b0, 1'b0);

    // Overflow saturation, negative sign
    send(16'h8000, 8'd31, 5'd0, 1'b1, 16'hFBFF, 1);
    drain();
    check_flags("sat", 1'b1, 1'b0, 1'b1);
    pulse_clr();
    check_flags("clr2", 1'b0, 1'b0, 1'b0);

    // Clear and set in the same cycle: set wins
    out_ready = 1'b0;
    send(16'h8000, 8'd31, 5'd0, 1'b0, 16'h7BFF, 1);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #3;
    check_flags("clr_vs_set", 1'b1, 1'b0, 1'b1);
    drain();
    pulse_clr();

    // Normal path patterns with rounding choices
`ifdef MAC_NORM_RNE_EN
    send(16'hFFF0, 8'd15, 5'd0, 1'b0, 16'h4000, 1);
    send(16'h8030, 8'd15, 5'd0, 1'b0, 16'h3C02, 1);
`else
    send(16'hFFF0, 8'd15, 5'd0, 1'b0, 16'h3FFF, 1);
    send(16'h8030, 8'd15, 5'd0, 1'b0, 16'h3C01, 1);
`endif
    send(16'h8010, 8'd15, 5'd0, 1'b0, 16'h3C00, 1); // tie, even LSB stays
    send(16'h0C00, 8'd15, 5'd0, 1'b0, 16'h2E00, 1);
    send(16'h8000, 8'd15, 5'd3, 1'b0, 16'h3000, 1);
    send(16'h0000, 8'd15, 5'd0, 1'b1, 16'h8000, 1);
    send(16'h8000, 8'hFB, 5'd0, 1'b0, 16'h0010, 1); // in_exp=-5
    drain();
    check_flags("norm", 1'b0, 1'b0, 1'b1);
    pulse_clr();

    // Subnormal rounding into exp=1, and rounding into saturation
`ifdef MAC_NORM_RNE_EN
    send(16'hFFFF, 8'd0, 5'd0, 1'b0, 16'h0400, 1);
    send(16'hFFFF, 8'd30, 5'd0, 1'b0, 16'h7BFF, 1);
    drain();
    check_flags("rnd_edge", 1'b1, 1'b0, 1'b1);
`else
    send(16'hFFFF, 8'd0, 5'd0, 1'b0, 16'h03FF, 1);
    send(16'hFFFF, 8'd30, 5'd0, 1'b0, 16'h7BFF, 1);
    drain();
    check_flags("rnd_edge", 1'b0, 1'b0, 1'b1);
`endif
    pulse_clr();

    // Back-to-back stream with a 4-cycle downstream stall
    fork
      begin
        send(16'h8000, 8'd15, 5'd0, 1'b0, 16'h3C00, 1);
        send(16'h8000, 8'd16, 5'd0, 1'b0, 16'h4000, 1);
        send(16'h8000, 8'd17, 5'd0, 1'b0, 16'h4400, 1);
        send(16'h8000, 8'd18, 5'd0, 1'b0, 16'h4800, 1);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: both dropped
    out_ready = 1'b0;
    send(16'h8000, 8'd20, 5'd0, 1'b0, 16'h0000, 0);
    send(16'h8000, 8'd21, 5'd0, 1'b0, 16'h0000, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_fp", {16'b0, out_fp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);

    // Pipeline still works after reset
    send(16'h8000, 8'd15, 5'd0, 1'b1, 16'hBC00, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
